// File: rtl/uart_pkg.sv
// Shared constants, state encodings and the clocks-per-bit helper for the 8N1 UART.
package uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic {TX_IDLE, TX_SHIFT} uart_tx_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

    // Truncating division: any fractional remainder becomes a small baud error.
    function automatic int clocks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_if.sv
// Parallel-side ready/valid handshakes of the UART; the host uses master and the core uses slave.
interface uart_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchronizer, mid-bit sampling FSM and holding register.
// Define UART_FRAMING_CHECK_EN to drop frames whose stop bit samples low.
module uart_receiver import uart_pkg::*; #(
    parameter int SYMBOL_EDGE = 868
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_in,
    input  logic                 data_out_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid
);
    localparam int CNT_W = $clog2(SYMBOL_EDGE + 1);

    uart_rx_state_t       rx_state, rx_next;
    logic [1:0]           sync;
    logic                 rx_line, sample, hold, frame_ok, deliver;
    logic [CNT_W-1:0]     rx_count;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;

    assign rx_line = sync[1];
    assign sample  = (rx_count == '0);
    assign deliver = (rx_state == RX_STOP) && sample && frame_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], s_in};
    end

`ifdef UART_FRAMING_CHECK_EN
    // A low stop bit may leave the line low; wait for it to go high before hunting for a start bit.
    assign frame_ok = rx_line;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        hold <= 1'b0;
        else if ((rx_state == RX_STOP) && sample && !rx_line) hold <= 1'b1;
        else if (rx_line)                                  hold <= 1'b0;
    end
`else
    assign frame_ok = 1'b1;
    assign hold     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_line && !hold) rx_next = RX_START;
            RX_START: if (sample) rx_next = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (sample && (rx_bit == 3'(DATA_BITS - 1))) rx_next = RX_STOP;
            RX_STOP:  if (sample) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Counter loads half a bit on the start edge so every later sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_bit <= '0;
            if (rx_next == RX_START) rx_count <= CNT_W'(SYMBOL_EDGE / 2);
        end else if (sample) begin
            rx_count <= CNT_W'(SYMBOL_EDGE - 1);
            if (rx_state == RX_DATA) begin
                rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end else begin
            rx_count <= rx_count - 1'b1;
        end
    end

    // A completing frame always wins over a consumer acknowledge, so overruns overwrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (deliver) begin
            data_out       <= rx_shift;
            data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: inline transmitter plus uart_receiver, parallel sides on uart_if.
// Define UART_FRAMING_CHECK_EN to discard received frames with a low stop bit.
module uart_core import uart_pkg::*; #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic  clk,
    input  logic  rst_n,
    uart_if.slave bus,
    input  logic  s_in,
    output logic  s_out
);
    localparam int SYMBOL_EDGE = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W       = $clog2(SYMBOL_EDGE + 1);

    uart_tx_state_t        tx_state, tx_next;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [CNT_W-1:0]      tx_count;
    logic [3:0]            tx_bit;
    logic                  tx_accept, tx_bit_end;

    assign bus.data_in_ready = (tx_state == TX_IDLE);
    assign tx_accept         = bus.data_in_valid && (tx_state == TX_IDLE);
    assign tx_bit_end        = (tx_count == CNT_W'(SYMBOL_EDGE - 1));
    // Shifting in ones means the line idles high once the stop bit has gone out.
    assign s_out             = tx_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (bus.data_in_valid) tx_next = TX_SHIFT;
            TX_SHIFT: if (tx_bit_end && (tx_bit == 4'(FRAME_BITS - 1))) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '1;
            tx_count <= '0;
            tx_bit   <= '0;
        end else if (tx_accept) begin
            tx_shift <= {1'b1, bus.data_in, 1'b0};
            tx_count <= '0;
            tx_bit   <= '0;
        end else if (tx_state == TX_SHIFT) begin
            if (tx_bit_end) begin
                tx_count <= '0;
                tx_bit   <= (tx_next == TX_IDLE) ? 4'd0 : tx_bit + 1'b1;
                tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
            end else begin
                tx_count <= tx_count + 1'b1;
            end
        end
    end

    uart_receiver #(.SYMBOL_EDGE(SYMBOL_EDGE)) u_receiver (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_in           (s_in),
        .data_out_ready (bus.data_out_ready),
        .data_out       (bus.data_out),
        .data_out_valid (bus.data_out_valid)
    );
endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: table-driven loopback frames, then overrun, glitch,
// mid-frame reset and stop-bit framing sequences.
module tb_uart_core;

    localparam int EDGE  = 868;
    localparam int BOUND = 20000;

    typedef struct {
        logic [7:0] tx_byte;
        logic [9:0] frame;
        logic       hold_valid;
        logic [7:0] next_in;
        logic [7:0] rx_byte;
    } vec_t;

    logic       clk, rst_n, s_in, s_out, loop_en, inj_line;
    logic [9:0] bad_frame;
    int         checks, errors;
    vec_t       vecs[4];

    uart_if u_if();

    uart_core #(.CLOCK_FREQ(100_000_000), .BAUD_RATE(115_200)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if),
        .s_in  (s_in),
        .s_out (s_out)
    );

    assign s_in = loop_en ? s_out : inj_line;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Entered at a falling edge; leaves at the falling edge just after the frame ends.
    task automatic apply_stimulus(input vec_t v);
        int   wait_cyc;
        int   low_cyc;
        logic got, pend;
        u_if.data_in       = v.tx_byte;
        u_if.data_in_valid = 1'b1;
        wait_cyc = 0;
        while (!u_if.data_in_ready && wait_cyc < BOUND) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_output("accept_wait", 32'(wait_cyc < BOUND), 32'd1);
        @(posedge clk);
        #1;
        u_if.data_in_valid = v.hold_valid;
        u_if.data_in       = v.next_in;
        low_cyc = 0;
        got     = 1'b0;
        pend    = 1'b0;
        for (int n = 1; n <= 10 * EDGE; n++) begin
            @(negedge clk);
            if (!u_if.data_in_ready) low_cyc++;
            if ((n - 1) % EDGE == EDGE / 2)
                check_output($sformatf("sout_bit%0d_%02h", (n - 1) / EDGE, v.tx_byte),
                             32'(s_out), 32'(v.frame[(n - 1) / EDGE]));
            if (pend) begin
                u_if.data_out_ready = 1'b0;
                pend = 1'b0;
                check_output("rx_valid_clear", 32'(u_if.data_out_valid), 32'd0);
            end else if (!got && u_if.data_out_valid) begin
                got = 1'b1;
                check_output($sformatf("rx_data_%02h", v.tx_byte), 32'(u_if.data_out), 32'(v.rx_byte));
                u_if.data_out_ready = 1'b1;
                pend = 1'b1;
            end
        end
        @(negedge clk);
        check_output("rx_seen", 32'(got), 32'd1);
        check_output("ready_low_cycles", 32'(low_cyc), 32'(10 * EDGE));
        check_output("ready_return", 32'(u_if.data_in_ready), 32'd1);
        check_output("sout_idle", 32'(s_out), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int settle);
        int wait_cyc;
        u_if.data_in       = b;
        u_if.data_in_valid = 1'b1;
        wait_cyc = 0;
        while (!u_if.data_in_ready && wait_cyc < BOUND) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_output("send_wait", 32'(wait_cyc < BOUND), 32'd1);
        @(posedge clk);
        #1;
        u_if.data_in_valid = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{8'h7A, 10'h2F4, 1'b0, 8'hC3, 8'h7A};
        vecs[1] = '{8'h55, 10'h2AA, 1'b0, 8'h81, 8'h55};
        vecs[2] = '{8'h00, 10'h200, 1'b1, 8'hFF, 8'h00};
        vecs[3] = '{8'hFF, 10'h3FE, 1'b0, 8'h0F, 8'hFF};
        bad_frame = 10'h14A;

        rst_n               = 1'b0;
        loop_en             = 1'b1;
        inj_line            = 1'b1;
        u_if.data_in        = 8'h00;
        u_if.data_in_valid  = 1'b0;
        u_if.data_out_ready = 1'b0;

        repeat (30) @(negedge clk);
        check_output("reset_sout", 32'(s_out), 32'd1);
        check_output("reset_in_ready", 32'(u_if.data_in_ready), 32'd1);
        check_output("reset_out_valid", 32'(u_if.data_out_valid), 32'd0);
        check_output("reset_data_out", 32'(u_if.data_out), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

        // Overrun: the second byte replaces the unconsumed first one.
        send_byte(8'h12, 10 * EDGE + 1);
        check_output("ovr_first_valid", 32'(u_if.data_out_valid), 32'd1);
        check_output("ovr_first_data", 32'(u_if.data_out), 32'h12);
        send_byte(8'h34, 10 * EDGE + 1);
        check_output("ovr_second_valid", 32'(u_if.data_out_valid), 32'd1);
        check_output("ovr_second_data", 32'(u_if.data_out), 32'h34);
        u_if.data_out_ready = 1'b1;
        @(negedge clk);
        u_if.data_out_ready = 1'b0;
        check_output("ovr_consumed", 32'(u_if.data_out_valid), 32'd0);

        // A 100-cycle low pulse is rejected at the mid-start-bit sample.
        loop_en  = 1'b0;
        inj_line = 1'b1;
        repeat (10) @(negedge clk);
        inj_line = 1'b0;
        repeat (100) @(negedge clk);
        inj_line = 1'b1;
        repeat (1500) @(negedge clk);
        check_output("glitch_no_byte", 32'(u_if.data_out_valid), 32'd0);

        // Reset in the middle of a transmitted frame.
        loop_en = 1'b1;
        send_byte(8'h55, 2000);
        check_output("midtx_busy", 32'(u_if.data_in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_output("midtx_reset_sout", 32'(s_out), 32'd1);
        check_output("midtx_reset_ready", 32'(u_if.data_in_ready), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xA5 with a low stop bit, driven directly onto the receive line.
        loop_en  = 1'b0;
        inj_line = 1'b1;
        repeat (20) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            inj_line = bad_frame[b];
            repeat (EDGE) @(negedge clk);
        end
        inj_line = 1'b1;
        repeat (EDGE) @(negedge clk);
`ifdef UART_FRAMING_CHECK_EN
        check_output("framing_dropped", 32'(u_if.data_out_valid), 32'd0);
        check_output("framing_data_kept", 32'(u_if.data_out), 32'h00);
`else
        check_output("framing_delivered", 32'(u_if.data_out_valid), 32'd1);
        check_output("framing_data", 32'(u_if.data_out), 32'hA5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
